// File: rtl/ecc_hamming_scrubber.sv
// Background scrubber for SECDED Hamming memory. It reads each address in turn, corrects
// single-bit errors by writing the fixed word back, and counts and flags uncorrectable words.
module ecc_hamming_scrubber #(
   parameter int unsigned D        = 8,
   parameter int unsigned C        = 12,
   parameter int unsigned AW       = 4,
   parameter int unsigned INTERVAL = 16,
   parameter int unsigned CW       = 16
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          enable,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [C:0]    mem_wdata,
   input  logic          mem_gnt,
   input  logic          mem_rvalid,
   input  logic [C:0]    mem_rdata,
   output logic [CW-1:0] corr_cnt,
   output logic [CW-1:0] uncorr_cnt,
   output logic [AW-1:0] err_addr,
   output logic          uncorr_pulse,
   output logic          sweep_done
);

   // One syndrome bit per Hamming parity bit.
   localparam int unsigned SW = C - D;
   localparam int unsigned TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StRdReq,
      StRdWait,
      StCheck,
      StWrReq,
      StNext
   } state_e;

   state_e        state;
   logic [AW-1:0] ptr;
   logic [TW-1:0] timer;
   logic [C:0]    rword;

   logic [SW-1:0] syndrome;
   logic          parity;
   logic          correctable;
   logic          uncorrectable;
   logic [C:0]    fixed_word;

   // Syndrome is the XOR of the Hamming positions (bit index + 1) of all set codeword bits.
   always_comb begin
      syndrome = '0;
      for (int i = 0; i < int'(C); i++) begin
         if (rword[i]) syndrome = syndrome ^ SW'(i + 1);
      end
   end

   // Classify the captured word and build its corrected form.
   always_comb begin
      parity        = ^rword;
      correctable   = parity && (32'(syndrome) <= C);
      uncorrectable = parity ? (32'(syndrome) > C) : (syndrome != '0);
      fixed_word    = rword;
      if (syndrome == '0) begin
         // Only the extra parity bit can be wrong.
         fixed_word[C] = ~rword[C];
      end else begin
         for (int i = 0; i < int'(C); i++) begin
            if (32'(syndrome) == 32'(i + 1)) fixed_word[i] = ~rword[i];
         end
      end
   end

   // Scrub FSM with registered memory-port and status outputs.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state        <= StIdle;
         ptr          <= '0;
         timer        <= '0;
         rword        <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         corr_cnt     <= '0;
         uncorr_cnt   <= '0;
         err_addr     <= '0;
         uncorr_pulse <= 1'b0;
         sweep_done   <= 1'b0;
      end else begin
         uncorr_pulse <= 1'b0;
         sweep_done   <= 1'b0;
         unique case (state)
            StIdle: begin
               if (enable) begin
                  if (timer == TW'(INTERVAL - 1)) begin
                     timer    <= '0;
                     state    <= StRdReq;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= ptr;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end else begin
                  timer <= '0;
               end
            end
            StRdReq: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= StRdWait;
               end
            end
            StRdWait: begin
               if (mem_rvalid) begin
                  rword <= mem_rdata;
                  state <= StCheck;
               end
            end
            StCheck: begin
               if (correctable) begin
                  if (corr_cnt != '1) corr_cnt <= corr_cnt + 1'b1;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_wdata <= fixed_word;
                  state     <= StWrReq;
               end else if (uncorrectable) begin
                  if (uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + 1'b1;
                  err_addr     <= ptr;
                  uncorr_pulse <= 1'b1;
                  state        <= StNext;
               end else begin
                  state <= StNext;
               end
            end
            StWrReq: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= StNext;
               end
            end
            StNext: begin
               ptr   <= ptr + 1'b1;
               if (ptr == '1) sweep_done <= 1'b1;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ecc_hamming_scrubber.sv
// Scoreboard bench: a memory model answers the scrubber, each accepted read pushes the
// expected write-back or error report, and the monitor pops and compares them.
module tb_ecc_hamming_scrubber;

   localparam int unsigned D        = 8;
   localparam int unsigned C        = 12;
   localparam int unsigned AW       = 4;
   localparam int unsigned INTERVAL = 16;
   localparam int unsigned CW       = 3;
   localparam int unsigned DEPTH    = 16;
   localparam int          CMAX     = 7;

   logic          clk = 1'b0;
   logic          rst_b = 1'b0;
   logic          enable = 1'b0;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [C:0]    mem_wdata;
   logic          mem_gnt = 1'b0;
   logic          mem_rvalid = 1'b0;
   logic [C:0]    mem_rdata = '0;
   logic [CW-1:0] corr_cnt, uncorr_cnt;
   logic [AW-1:0] err_addr;
   logic          uncorr_pulse, sweep_done;

   always #5 clk = ~clk;

   ecc_hamming_scrubber #(.D(D), .C(C), .AW(AW), .INTERVAL(INTERVAL), .CW(CW)) dut (
      .clk(clk), .rst_b(rst_b), .enable(enable),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .err_addr(err_addr),
      .uncorr_pulse(uncorr_pulse), .sweep_done(sweep_done)
   );

   int checks = 0;
   int errors = 0;

   // Stimulus controls written by the main process only.
   int         stall_max = 0, rvd_max = 1;
   bit         stall_fix = 1'b0, rvd_fix = 1'b1, spur_en = 1'b0, lat_en = 1'b0;
   logic [C:0] init_mem [DEPTH];
   int         load_seq = 0;

   // Memory, model and scoreboard state written by the monitor only.
   logic [C:0]    mem [DEPTH];
   int            load_done = 0;
   logic [AW+C:0] wq[$];
   logic [AW-1:0] uq[$];
   int model_ptr = 0, model_corr = 0, model_uncorr = 0, model_err = 0;
   int sweeps_exp = 0, sweeps_seen = 0, reads_seen = 0, writes_seen = 0, last_rd_addr = 0;
   int cyc = 0, stall_left = 0, rv_left = 0, last_rd_cyc = 0;
   bit have_prev = 0, have_last_rd = 0, last_was_corr = 0;
   logic [C:0]    rv_word;
   logic          prev_we;
   logic [AW-1:0] prev_addr;
   logic [C:0]    prev_wdata;

   logic [C:0] valid_words[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // A stored word is a codeword when its set positions XOR to zero and its weight is even.
   function automatic bit is_code(input logic [C:0] w);
      int s = 0;
      for (int i = 0; i < int'(C); i++) if (w[i]) s = s ^ (i + 1);
      return (s == 0) && (^w == 1'b0);
   endfunction

   // Nearest-codeword decode: 0 clean, 1 one flip away (fixed returned), 2 otherwise.
   function automatic int classify(input logic [C:0] w, output logic [C:0] fixed);
      logic [C:0] t;
      fixed = w;
      if (is_code(w)) return 0;
      for (int j = 0; j <= int'(C); j++) begin
         t = w;
         t[j] = ~t[j];
         if (is_code(t)) begin
            fixed = t;
            return 1;
         end
      end
      return 2;
   endfunction

   function automatic int new_stall();
      return stall_fix ? stall_max : int'($urandom_range(stall_max, 0));
   endfunction

   function automatic int new_rvd();
      return rvd_fix ? rvd_max : int'($urandom_range(rvd_max, 1));
   endfunction

   task automatic accept();
      logic [C:0]    fixed;
      logic [AW+C:0] e;
      int            kind;
      if (mem_we) begin
         if (wq.size() == 0) begin
            chk("wr_unexpected", 32'(wq.size()), 1);
         end else begin
            e = wq.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(e[AW+C:C+1]));
            chk("wr_data", 32'(mem_wdata), 32'(e[C:0]));
         end
         mem[mem_addr] = mem_wdata;
         writes_seen++;
      end else begin
         chk("rd_addr", 32'(mem_addr), 32'(model_ptr));
         chk("wq_drained_at_read", 32'(wq.size()), 0);
         chk("uq_drained_at_read", 32'(uq.size()), 0);
         if (lat_en && have_last_rd)
            chk("latency", 32'(cyc - last_rd_cyc), 32'(INTERVAL + 4 + (last_was_corr ? 1 : 0)));
         have_last_rd = 1;
         last_rd_cyc  = cyc;
         rv_word = mem[mem_addr];
         rv_left = new_rvd();
         kind = classify(rv_word, fixed);
         last_was_corr = (kind == 1);
         if (kind == 1) begin
            wq.push_back({mem_addr, fixed});
            if (model_corr < CMAX) model_corr++;
         end else if (kind == 2) begin
            uq.push_back(mem_addr);
            if (model_uncorr < CMAX) model_uncorr++;
            model_err = int'(mem_addr);
         end
         if (int'(mem_addr) == DEPTH - 1) sweeps_exp++;
         model_ptr    = (model_ptr + 1) % DEPTH;
         last_rd_addr = int'(mem_addr);
         reads_seen++;
      end
   endtask

   // Memory model and monitor; acts on the falling edge, so the DUT samples at the next rise.
   always @(negedge clk) begin
      cyc++;
      if (load_seq != load_done) begin
         for (int a = 0; a < DEPTH; a++) mem[a] = init_mem[a];
         load_done = load_seq;
      end
      if (!lat_en) have_last_rd = 0;
      if (!rst_b) begin
         wq.delete();
         uq.delete();
         model_ptr = 0; model_corr = 0; model_uncorr = 0; model_err = 0;
         mem_gnt = 1'b0; mem_rvalid = 1'b0; rv_left = 0;
         stall_left = new_stall(); have_prev = 0; have_last_rd = 0;
      end else begin
         mem_rvalid = 1'b0;
         if (rv_left > 0) begin
            rv_left--;
            if (rv_left == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rv_word;
            end
         end else if (spur_en && $urandom_range(3) == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 13'($urandom);
         end
         if (have_prev) begin
            chk("stall_req", 32'(mem_req), 1);
            chk("stall_we", 32'(mem_we), 32'(prev_we));
            chk("stall_addr", 32'(mem_addr), 32'(prev_addr));
            if (prev_we) chk("stall_wdata", 32'(mem_wdata), 32'(prev_wdata));
         end
         have_prev = 0;
         mem_gnt   = 1'b0;
         if (mem_req) begin
            if (stall_left > 0) begin
               stall_left--;
               have_prev  = 1;
               prev_we    = mem_we;
               prev_addr  = mem_addr;
               prev_wdata = mem_wdata;
            end else begin
               mem_gnt = 1'b1;
               accept();
               stall_left = new_stall();
            end
         end else if (spur_en && $urandom_range(3) == 0) begin
            mem_gnt = 1'b1;
         end
         if (uncorr_pulse) begin
            if (uq.size() == 0) chk("uncorr_unexpected", 32'(uq.size()), 1);
            else chk("err_addr_at_pulse", 32'(err_addr), 32'(uq.pop_front()));
         end
         if (sweep_done) sweeps_seen++;
      end
   end

   task automatic load_and_sync();
      load_seq++;
      @(negedge clk);
      #1;
   endtask

   task automatic end_checks(input string tag);
      chk({tag, "_corr_cnt"}, 32'(corr_cnt), 32'(model_corr));
      chk({tag, "_uncorr_cnt"}, 32'(uncorr_cnt), 32'(model_uncorr));
      chk({tag, "_err_addr"}, 32'(err_addr), 32'(model_err));
      chk({tag, "_wq_empty"}, 32'(wq.size()), 0);
      chk({tag, "_uq_empty"}, 32'(uq.size()), 0);
      chk({tag, "_sweeps"}, 32'(sweeps_seen), 32'(sweeps_exp));
   endtask

   task automatic wait_sweeps(input int target, input int budget, input string name);
      int n = 0;
      while (sweeps_seen < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk(name, 32'(sweeps_seen >= target), 1);
   endtask

   task automatic wait_reads(input int target, input int budget, input string name);
      int n = 0;
      while (reads_seen < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk(name, 32'(reads_seen >= target), 1);
   endtask

   initial begin
      int r0, w0;
      logic [C:0] w;
      int n;
      for (int v = 0; v < (1 << (C + 1)); v++) if (is_code(13'(v))) valid_words.push_back(13'(v));
      for (int a = 0; a < DEPTH; a++) init_mem[a] = '0;
      load_and_sync();

      // Reset state.
      repeat (3) @(negedge clk);
      #1;
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_corr_cnt", 32'(corr_cnt), 0);
      chk("rst_uncorr_cnt", 32'(uncorr_cnt), 0);
      chk("rst_err_addr", 32'(err_addr), 0);
      chk("rst_uncorr_pulse", 32'(uncorr_pulse), 0);
      chk("rst_sweep_done", 32'(sweep_done), 0);
      rst_b = 1'b1;

      // Directed zero-wait sweep: single, parity-only, double and out-of-range errors.
      init_mem[3] = 13'h0010;
      init_mem[7] = 13'h1000;
      init_mem[5] = 13'h0014;
      init_mem[9] = 13'h0089;
      load_and_sync();
      lat_en = 1'b1;
      enable = 1'b1;
      wait_sweeps(1, 800, "dir_sweep_timeout");
      enable = 1'b0;
      lat_en = 1'b0;
      repeat (30) @(negedge clk);
      #1;
      end_checks("dir");
      chk("dir_corr_const", 32'(corr_cnt), 2);
      chk("dir_uncorr_const", 32'(uncorr_cnt), 2);
      chk("dir_err_addr_const", 32'(err_addr), 9);
      chk("dir_mem3", 32'(mem[3]), 0);
      chk("dir_mem7", 32'(mem[7]), 0);
      chk("dir_mem5_untouched", 32'(mem[5]), 32'h0014);
      chk("dir_mem9_untouched", 32'(mem[9]), 32'h0089);
      chk("dir_reads", 32'(reads_seen), 16);
      chk("dir_writes", 32'(writes_seen), 2);
      chk("dir_ptr_wrapped", 32'(model_ptr), 0);

      // Random contents, random stalls and rvalid delays, spurious gnt/rvalid.
      for (int a = 0; a < DEPTH; a++) begin
         w = valid_words[$urandom_range(valid_words.size() - 1)];
         n = int'($urandom_range(3));
         for (int k = 0; k < n; k++) begin
            int idx = int'($urandom_range(C));
            w[idx] = ~w[idx];
         end
         init_mem[a] = w;
      end
      load_and_sync();
      stall_max = 3; stall_fix = 1'b0; rvd_max = 3; rvd_fix = 1'b0; spur_en = 1'b1;
      enable = 1'b1;
      wait_sweeps(3, 4000, "rand_sweep_timeout");
      enable = 1'b0;
      repeat (60) @(negedge clk);
      spur_en = 1'b0;
      #1;
      end_checks("rand");

      // Long grant stalls on reads and write-backs; rvalid three cycles after grant.
      for (int a = 0; a < DEPTH; a++) init_mem[a] = 13'h0010;
      load_and_sync();
      stall_max = 10; stall_fix = 1'b1; rvd_max = 3; rvd_fix = 1'b1;
      r0 = reads_seen;
      w0 = writes_seen;
      enable = 1'b1;
      wait_reads(r0 + 3, 600, "stall_timeout");
      enable = 1'b0;
      repeat (80) @(negedge clk);
      #1;
      end_checks("stall");
      chk("stall_writes", 32'(writes_seen - w0), 3);

      // Enable drop during the read of address 2; write-back completes, pointer parks at 3.
      rst_b = 1'b0;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      for (int a = 0; a < DEPTH; a++) init_mem[a] = '0;
      init_mem[2] = 13'h0010;
      init_mem[4] = 13'h0010;
      load_and_sync();
      stall_max = 0; rvd_max = 1;
      r0 = reads_seen;
      w0 = writes_seen;
      enable = 1'b1;
      wait_reads(r0 + 3, 300, "drop_timeout");
      @(posedge clk);
      #1;
      enable = 1'b0;
      repeat (60) @(negedge clk);
      #1;
      chk("drop_writeback", 32'(writes_seen - w0), 1);
      chk("drop_parked", 32'(reads_seen - r0), 3);
      chk("drop_mem2", 32'(mem[2]), 0);
      chk("drop_corr_cnt", 32'(corr_cnt), 1);
      chk("drop_idle_req", 32'(mem_req), 0);
      stall_max = 10;
      enable = 1'b1;
      wait_reads(r0 + 4, 200, "resume_timeout");
      chk("resume_addr", 32'(last_rd_addr), 3);

      // Asynchronous reset while a write-back request is stalled.
      n = 0;
      while (!(mem_req && mem_we) && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("wrreq_seen", 32'(mem_req && mem_we), 1);
      chk("pre_rst_corr_cnt", 32'(corr_cnt), 2);
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      #1;
      chk("arst_mem_req", 32'(mem_req), 0);
      chk("arst_mem_we", 32'(mem_we), 0);
      chk("arst_corr_cnt", 32'(corr_cnt), 0);
      chk("arst_uncorr_cnt", 32'(uncorr_cnt), 0);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      end_checks("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ecc_hamming_scrubber.md
Name: ecc_hamming_scrubber

Overview:
- Background memory scrubber for Hamming SECDED-protected storage.
- Walks every address of an external ECC memory and reads each stored codeword plus its extra parity bit.
- Computes syndrome and overall parity, then writes back the corrected word on a single-bit error; double and uncorrectable errors are counted and flagged without writing.
- Shares the memory port with functional traffic through a req/gnt handshake and sits beside the Hamming encoder in the ECC subsystem.

Parameters:
- D, 8: data bits per word.
- C, 12: Hamming codeword bits. C must satisfy 2^(C-D) >= C+1; stored word is C+1 bits.
- AW, 4: memory address width. DEPTH = 2^AW.
- INTERVAL, 16: idle cycles between consecutive address checks (>=1).
- CW, 16: width of the error counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- enable  in  1  level; scrubbing runs while high.
- mem_req  out  1  memory access request.
- mem_we  out  1  1=write, 0=read; valid with mem_req.
- mem_addr  out  AW  access address.
- mem_wdata  out  C+1  write word: [C]=extra parity, [C-1:0]=codeword.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid (>=1 cycle after read grant).
- mem_rdata  in  C+1  read word, same layout as mem_wdata.
- corr_cnt  out  CW  corrected single errors, saturating.
- uncorr_cnt  out  CW  uncorrectable errors, saturating.
- err_addr  out  AW  address of the most recent uncorrectable error.
- uncorr_pulse  out  1  1-cycle pulse per uncorrectable detection.
- sweep_done  out  1  1-cycle pulse when address DEPTH-1 completes.

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; address pointer 0; interval timer 0.
- Codeword convention:
  - Codeword bit i holds Hamming position i+1.
  - Parity bits sit at power-of-two positions.
  - Syndrome S = XOR of the positions of all set codeword bits.
  - Overall parity P = XOR of all C+1 stored bits.
- Classification, one CHECK cycle:
  - S=0, P=0: clean; no write.
  - P=1, S=0: extra parity bit flipped; write back with bit [C] inverted.
  - P=1, 1<=S<=C: invert codeword bit S-1 and write back.
  - P=1, S>C: uncorrectable.
  - P=0, S!=0: double error, uncorrectable.
- FSM states:
  - IDLE: timer counts while enable=1. When timer reaches INTERVAL-1, clear timer and go to RD_REQ. Timer holds at 0 while enable=0.
  - RD_REQ: mem_req=1, mem_we=0, mem_addr=pointer. Held stable until mem_gnt, then go to RD_WAIT.
  - RD_WAIT: capture mem_rdata on mem_rvalid, then go to CHECK.
  - CHECK: classify.
    - Correctable: increment corr_cnt, go to WR_REQ.
    - Uncorrectable: increment uncorr_cnt, load err_addr, pulse uncorr_pulse, go to NEXT.
    - Clean: go to NEXT.
  - WR_REQ: mem_req=1, mem_we=1, mem_wdata=corrected word. Held stable until mem_gnt, then go to NEXT.
  - NEXT: increment the pointer, wrapping DEPTH-1 to 0. On wrap, pulse sweep_done. Go to IDLE.
- Counters saturate at 2^CW-1 and never wrap.
- enable falling mid-access: the current address completes, including any write-back, then the FSM parks in IDLE. The pointer is retained and resumes on the next enable.
- mem_rvalid outside RD_WAIT is ignored.
- mem_gnt while mem_req=0 is ignored.
- Async reset mid-access drops mem_req immediately and clears all state.
- Per-address latency with zero-wait memory (gnt same cycle, rvalid next cycle): INTERVAL + 4 cycles clean, INTERVAL + 5 with write-back.

Test Plan:
- Clean sweep:
  - Stimulus: AW=4, all words 13'h0000, enable=1, immediate gnt.
  - Response: 16 reads and no writes; sweep_done pulses once after addr 15; counters stay 0; pointer returns to 0.
- Single data-bit error:
  - Stimulus: addr 3 holds 13'h0010 (position 5 flipped).
  - Response: write to addr 3 with 13'h0000; corr_cnt=1; uncorr_pulse stays 0.
- Extra-parity-only error:
  - Stimulus: addr 7 holds 13'h1000.
  - Response: write 13'h0000 to addr 7; corr_cnt=1.
- Double and out-of-range errors:
  - Stimulus: addr 5 = 13'h0014 (S=6, P=0); addr 9 = 13'h0089 (S=13, P=1).
  - Response: no writes; uncorr_cnt=2; err_addr=9 after the sweep; two uncorr_pulse.
- Grant stall and latency:
  - Stimulus: hold mem_gnt low 10 cycles during RD_REQ and WR_REQ; rvalid returns 3 cycles after grant.
  - Response: mem_req, mem_addr and mem_wdata stay stable throughout the stall; a single access occurs per grant.
- Enable drop and reset:
  - Stimulus: drop enable in RD_WAIT at addr 2 holding 13'h0010.
  - Response: write-back still completes; FSM parks in IDLE at pointer 3. Asserting rst_b=0 in WR_REQ clears mem_req the same cycle and zeroes the counters.
